uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver: the downstream counterpart of uart_tx, consuming the serial line that uart_tx drives on tx_out. It recovers one frame (start, DATA_WIDTH data bits LSB first, optional parity, stop) and presents the word on a parallel output with a one-cycle valid strobe. Parity and stop-bit errors are flagged per frame. Parity configuration matches uart_tx's par_en/par_typ, so the two blocks can be looped back in the UART top-level and bench.

## Interface
- DATA_WIDTH, 8, data bits per frame
- clk  input  1  receiver clock; runs at prescale × bit rate
- res_n  input  1  reset; synchronous, active-low
- rx_in  input  1  serial line, asynchronous to clk, idle high
- prescale  input  6  oversampling ratio; legal values 8, 16, 32; any other value is treated as 8
- par_en  input  1  1 = parity bit present
- par_typ  input  1  0 = even parity, 1 = odd parity
- p_data  output  DATA_WIDTH  last correctly received word
- data_valid  output  1  one-cycle strobe: p_data updated this cycle
- par_err  output  1  one-cycle strobe: parity mismatch on the just-ended frame
- stp_err  output  1  one-cycle strobe: stop bit sampled 0 on the just-ended frame

## Operation
- rx_in passes through a 2-flop synchronizer, reset to 1; everything below uses the synchronized value `rxs`.
- prescale, par_en and par_typ are captured at start detection and held for the whole frame.
- Per bit, an edge counter runs 0..P-1, where P is the captured prescale. A bit counter counts data bits.
- Each bit value is the majority of three samples taken at edges P/2-1, P/2 and P/2+1. The bit is decided at edge P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rxs==0, go to START. The detection cycle counts as edge 0 of the start bit.
- START: the start bit is decided at edge P/2+1.
  - Decided 1 (glitch): return to IDLE immediately. No output strobes.
  - Decided 0: at edge P-1, go to DATA.
- DATA: each decided bit shifts into bit_cnt position (LSB first). After DATA_WIDTH bits, at edge P-1, go to PARITY if par_en, else STOP.
- PARITY: the expected bit is XOR of the data bits, XOR par_typ. Record a mismatch. At edge P-1, go to STOP.
- STOP: at edge P-1, go to IDLE and evaluate the frame:
  - stop bit 1 and no parity mismatch: load p_data, pulse data_valid.
  - otherwise: pulse par_err and/or stp_err (both may pulse together). data_valid stays 0 and p_data is unchanged.
- Line held low (break): the frame completes with stp_err. IDLE then sees rxs==0 on the next cycle and starts a new frame. This behaviour is accepted.
- Reset (any state, including mid-frame): FSM to IDLE, counters 0, p_data 0, all strobes 0, synchronizer flops 1.

## Timing
- All outputs are registered. Reset values: p_data=0, data_valid=0, par_err=0, stp_err=0.
- Frame length N = 2 + DATA_WIDTH + par_en bits.
- Let T be the cycle IDLE sees rxs==0. The STOP last edge falls at T + N·P − 1, and the strobes are high in cycle T + N·P, for exactly one cycle.
- A raw rx_in falling edge sampled at clk cycle t0 gives T = t0 + 2.
- The FSM is back in IDLE in the strobe cycle. A next start bit sampled in that cycle is detected (zero dead time).
- The idle line produces no strobes. A start low shorter than P/2 − 1 cycles never produces a frame.
- p_data holds its value until the next good frame.

## Test plan
- **Basic frame:** prescale=8, par_en=0, send 0xA5 → data_valid one cycle at T+80, p_data=0xA5, no errors.
- **Even parity:** prescale=16, par_en=1, par_typ=0, send 0x3C with parity bit 0 → p_data=0x3C at T+176. Resend with parity bit 1 → par_err only, p_data stays 0x3C.
- **Odd parity and stop error:** prescale=32, odd parity, send 0x01 with parity 0 → p_data=0x01. Send 0x02 with stop bit 0 → stp_err only.
- **Glitch rejection:** rx_in low for 3 cycles at prescale=16 → stays IDLE, no strobes. A following good 0x5A frame is received correctly.
- **Back-to-back frames:** prescale=8, 0x11 then 0xEE with no idle gap → two data_valid strobes exactly 80 cycles apart, values in order.
- **Reset mid-frame:** res_n=0 for 1 cycle during DATA → all outputs 0 next cycle. A subsequent 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, data LSB first, optional parity, stop.
// Majority-of-three sampling around mid-bit; per-frame error strobes.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t                state;
  logic                  sync1;
  logic                  rxs;
  logic [5:0]            p;
  logic [5:0]            p_sel;
  logic [5:0]            edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  pen;
  logic                  ptyp;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  smp0;
  logic                  smp1;
  logic                  par_bad;
  logic                  stop_bit;

  logic [5:0] half;
  logic       at_s0;
  logic       at_s1;
  logic       at_dec;
  logic       at_last;
  logic       bit_val;

  always_comb begin
    p_sel = 6'd8;
    unique case (1'b1)
      (prescale == 6'd16): p_sel = 6'd16;
      (prescale == 6'd32): p_sel = 6'd32;
      default:             p_sel = 6'd8;
    endcase
  end

  assign half    = p >> 1;
  assign at_s0   = (edge_cnt == half - 6'd1);
  assign at_s1   = (edge_cnt == half);
  assign at_dec  = (edge_cnt == half + 6'd1);
  assign at_last = (edge_cnt == p - 6'd1);
  assign bit_val = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state      <= IDLE;
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      p          <= 6'd8;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      pen        <= 1'b0;
      ptyp       <= 1'b0;
      shreg      <= '0;
      smp0       <= 1'b1;
      smp1       <= 1'b1;
      par_bad    <= 1'b0;
      stop_bit   <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      sync1      <= rx_in;
      rxs        <= sync1;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state != IDLE) begin
        edge_cnt <= at_last ? 6'd0 : edge_cnt + 6'd1;
        if (at_s0) smp0 <= rxs;
        if (at_s1) smp1 <= rxs;
      end

      case (state)
        IDLE: begin
          // detection cycle is edge 0 of the start bit
          if (!rxs) begin
            state    <= START;
            edge_cnt <= 6'd1;
            p        <= p_sel;
            pen      <= par_en;
            ptyp     <= par_typ;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
          end
        end
        START: begin
          if (at_dec && bit_val) begin
            state    <= IDLE;
            edge_cnt <= 6'd0;
          end else if (at_last) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (at_dec) shreg[bit_cnt] <= bit_val;
          if (at_last) begin
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= pen ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (at_dec) par_bad <= bit_val ^ (^shreg) ^ ptyp;
          if (at_last) state <= STOP;
        end
        STOP: begin
          if (at_dec) stop_bit <= bit_val;
          if (at_last) begin
            state <= IDLE;
            if (stop_bit && !par_bad) begin
              p_data     <= shreg;
              data_valid <= 1'b1;
            end else begin
              par_err <= par_bad;
              stp_err <= !stop_bit;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level model predicts strobe cycle
// and outcome; a negedge process compares every cycle.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       res_n;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk(clk),
    .res_n(res_n),
    .rx_in(rx_in),
    .prescale(prescale),
    .par_en(par_en),
    .par_typ(par_typ),
    .p_data(p_data),
    .data_valid(data_valid),
    .par_err(par_err),
    .stp_err(stp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] d;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         rst_cyc = -1;
  logic [7:0] exp_pdata = 8'h00;
  int         dv_cyc = -1;
  int         dv_prev = -1;
  int         pe_cyc = -1;
  int         se_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // per-cycle compare against the frame model
  always @(negedge clk) begin
    bit   e_dv, e_pe, e_se;
    ev_t  e;
    e_dv = 0; e_pe = 0; e_se = 0;
    if (cyc == rst_cyc) exp_pdata = 8'h00;
    if (evq.size() > 0 && evq[0].cyc == cyc) begin
      e = evq.pop_front();
      e_dv = e.dv; e_pe = e.pe; e_se = e.se;
      if (e.dv) exp_pdata = e.d;
    end
    tests++;
    if ({p_data, data_valid, par_err, stp_err} !==
        {exp_pdata, e_dv, e_pe, e_se}) begin
      fails++;
      $display("FAIL cycle %0d outputs: got d=%h v=%b pe=%b se=%b want d=%h v=%b pe=%b se=%b",
               cyc, p_data, data_valid, par_err, stp_err,
               exp_pdata, e_dv, e_pe, e_se);
    end
    if (data_valid === 1'b1) begin dv_prev = dv_cyc; dv_cyc = cyc; end
    if (par_err === 1'b1) pe_cyc = cyc;
    if (stp_err === 1'b1) se_cyc = cyc;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drive one frame; the model decides its outcome and strobe cycle
  task automatic send(input logic [7:0] d, input int pre, input bit pe,
                      input bit pt, input bit pbit, input bit stop,
                      output int k);
    bit   bits[12];
    int   n, eff;
    ev_t  e;
    eff = (pre == 16 || pre == 32) ? pre : 8;
    n = 10 + int'(pe);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    if (pe) bits[9] = pbit;
    bits[n - 1] = stop;
    prescale = 6'(pre);
    par_en = pe;
    par_typ = pt;
    k = cyc;
    e.cyc = k + 2 + n * eff;
    e.pe = pe && (pbit != ((^d) ^ pt));
    e.se = !stop;
    e.dv = !e.pe && !e.se;
    e.d = d;
    evq.push_back(e);
    for (int j = 0; j < n; j++) begin
      rx_in = bits[j];
      repeat (eff) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int k, k2;
    res_n = 1'b0;
    rx_in = 1'b1;
    prescale = 6'd8;
    par_en = 1'b0;
    par_typ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pdata", int'(p_data), 0);
    check("reset_strobes", int'({data_valid, par_err, stp_err}), 0);
    res_n = 1'b1;
    idle(5);

    // basic frame at prescale 8
    send(8'hA5, 8, 0, 0, 0, 1, k);
    idle(6);
    check("basic_time", dv_cyc - k, 82);
    check("basic_data", int'(p_data), 8'hA5);

    // even parity good, then bad parity bit
    send(8'h3C, 16, 1, 0, 0, 1, k);
    idle(6);
    check("even_time", dv_cyc - k, 178);
    check("even_data", int'(p_data), 8'h3C);
    send(8'h3C, 16, 1, 0, 1, 1, k);
    idle(6);
    check("even_perr_time", pe_cyc - k, 178);
    check("even_perr_hold", int'(p_data), 8'h3C);

    // odd parity good, then stop error
    send(8'h01, 32, 1, 1, 0, 1, k);
    idle(6);
    check("odd_data", int'(p_data), 8'h01);
    send(8'h02, 32, 1, 1, 0, 0, k);
    idle(6);
    check("stop_err_time", se_cyc - k, 354);
    check("stop_err_hold", int'(p_data), 8'h01);

    // short glitch at prescale 16, then a good frame
    prescale = 6'd16;
    par_en = 1'b0;
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(40);
    send(8'h5A, 16, 0, 0, 0, 1, k);
    idle(6);
    check("glitch_then_data", int'(p_data), 8'h5A);

    // back-to-back frames, no idle gap
    send(8'h11, 8, 0, 0, 0, 1, k);
    send(8'hEE, 8, 0, 0, 0, 1, k2);
    idle(6);
    check("b2b_spacing", dv_cyc - dv_prev, 80);
    check("b2b_second", int'(p_data), 8'hEE);

    // unsupported prescale falls back to 8
    send(8'h96, 12, 0, 0, 0, 1, k);
    idle(6);
    check("pre12_time", dv_cyc - k, 82);

    // reset in the middle of the data bits
    prescale = 6'd8;
    rx_in = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    evq.delete();
    rst_cyc = cyc + 1;
    res_n = 1'b0;
    @(posedge clk);
    #1;
    res_n = 1'b1;
    check("midrst_pdata", int'(p_data), 0);
    idle(20);
    send(8'hC3, 8, 0, 0, 0, 1, k);
    idle(6);
    check("after_rst_data", int'(p_data), 8'hC3);
    check("after_rst_time", dv_cyc - k, 82);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
